// File: rtl/idex_pipe_reg_pkg.sv
// Shared widths, control-bit indices and the bubble constant for the pipeline registers.
// Build option: LOAD_USE_DETECT_EN enables in-block load-use hazard detection.
package idex_pipe_reg_pkg;

   localparam int DATA_W_D    = 32;
   localparam int RADDR_W_D   = 5;
   localparam int FUNCT_W_D   = 6;
   localparam int EXCTRL_W_D  = 4;
   localparam int MEMCTRL_W_D = 2;
   localparam int WBCTRL_W_D  = 2;

   localparam int MEMRD_BIT    = 1;
   localparam int MEMWR_BIT    = 0;
   localparam int REGWR_BIT    = 1;
   localparam int MEMTOREG_BIT = 0;

   // Wide enough for any stage's concatenated control bundle.
   localparam int CTRL_MAX_W = 64;
   localparam logic [CTRL_MAX_W-1:0] ZERO_CTRL = '0;

endpackage

// File: rtl/idex_pipe_reg_ctrl_slot.sv
// Valid bit plus control bundle with rst > flush > stall > load priority.
// A killed or invalid slot carries an all-zero bundle, so it has no side effects.
module pipe_ctrl_slot
   import idex_pipe_reg_pkg::*;
#(
   parameter int CTRL_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              i_valid,
   input  logic [CTRL_W-1:0] i_ctrl,
   output logic              o_valid,
   output logic [CTRL_W-1:0] o_ctrl
);

   logic              r_valid;
   logic [CTRL_W-1:0] r_ctrl;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_ctrl  <= ZERO_CTRL[CTRL_W-1:0];
      end else if (flush) begin
         r_valid <= 1'b0;
         r_ctrl  <= ZERO_CTRL[CTRL_W-1:0];
      end else if (!stall) begin
         r_valid <= i_valid;
         r_ctrl  <= i_valid ? i_ctrl : ZERO_CTRL[CTRL_W-1:0];
      end
   end

   assign o_valid = r_valid;
   assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with valid, stall, flush and optional load-use bubble.
// Build option: LOAD_USE_DETECT_EN enables in-block load-use hazard detection.
module idex_pipe_reg
   import idex_pipe_reg_pkg::*;
#(
   parameter int DATA_W    = DATA_W_D,
   parameter int RADDR_W   = RADDR_W_D,
   parameter int FUNCT_W   = FUNCT_W_D,
   parameter int EXCTRL_W  = EXCTRL_W_D,
   parameter int MEMCTRL_W = MEMCTRL_W_D,
   parameter int WBCTRL_W  = WBCTRL_W_D
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 id_valid,
   input  logic [DATA_W-1:0]    readData1,
   input  logic [DATA_W-1:0]    readData2,
   input  logic [DATA_W-1:0]    offset,
   input  logic [RADDR_W-1:0]   rs,
   input  logic [RADDR_W-1:0]   rt,
   input  logic [RADDR_W-1:0]   rd,
   input  logic [RADDR_W-1:0]   shamt,
   input  logic [FUNCT_W-1:0]   funct,
   input  logic [EXCTRL_W-1:0]  exctrl,
   input  logic [MEMCTRL_W-1:0] memCtrl,
   input  logic [WBCTRL_W-1:0]  wbctrl,
   input  logic                 Branch_D,
   output logic                 IDEX_valid,
   output logic [DATA_W-1:0]    IDEX_readData1,
   output logic [DATA_W-1:0]    IDEX_readData2,
   output logic [DATA_W-1:0]    IDEX_offset,
   output logic [RADDR_W-1:0]   IDEX_rs,
   output logic [RADDR_W-1:0]   IDEX_rt,
   output logic [RADDR_W-1:0]   IDEX_rd,
   output logic [RADDR_W-1:0]   IDEX_shamt,
   output logic [FUNCT_W-1:0]   IDEX_funct,
   output logic [EXCTRL_W-1:0]  IDEX_exctrl,
   output logic [MEMCTRL_W-1:0] IDEX_memCtrl,
   output logic [WBCTRL_W-1:0]  IDEX_wbctrl,
   output logic                 IDEX_Branch,
   output logic                 load_use_hazard
);

   localparam int CTRL_W = EXCTRL_W + MEMCTRL_W + WBCTRL_W + 1;
   localparam int WB_LO  = 1;
   localparam int MEM_LO = WB_LO + WBCTRL_W;
   localparam int EX_LO  = MEM_LO + MEMCTRL_W;

   logic              w_kill;
   logic              w_valid;
   logic [CTRL_W-1:0] w_ctrl_in;
   logic [CTRL_W-1:0] w_ctrl;

   logic [DATA_W-1:0]  r_rd1;
   logic [DATA_W-1:0]  r_rd2;
   logic [DATA_W-1:0]  r_off;
   logic [RADDR_W-1:0] r_rs;
   logic [RADDR_W-1:0] r_rt;
   logic [RADDR_W-1:0] r_rd;
   logic [RADDR_W-1:0] r_shamt;
   logic [FUNCT_W-1:0] r_funct;

`ifdef LOAD_USE_DETECT_EN
   assign load_use_hazard = w_valid
                          & w_ctrl[MEM_LO + MEMRD_BIT]
                          & (r_rt != '0)
                          & id_valid
                          & ((r_rt == rs) | (r_rt == rt));
`else
   assign load_use_hazard = 1'b0;
`endif

   // A load-use bubble kills the slot exactly like a flush.
   assign w_kill    = flush | load_use_hazard;
   assign w_ctrl_in = {exctrl, memCtrl, wbctrl, Branch_D};

   pipe_ctrl_slot #(
      .CTRL_W (CTRL_W)
   ) u_ctrl (
      .clk     (clk),
      .rst     (rst),
      .stall   (stall),
      .flush   (w_kill),
      .i_valid (id_valid),
      .i_ctrl  (w_ctrl_in),
      .o_valid (w_valid),
      .o_ctrl  (w_ctrl)
   );

   // Datapath fields still load on a kill so their contents stay deterministic.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd1   <= '0;
         r_rd2   <= '0;
         r_off   <= '0;
         r_rs    <= '0;
         r_rt    <= '0;
         r_rd    <= '0;
         r_shamt <= '0;
         r_funct <= '0;
      end else if (w_kill || !stall) begin
         r_rd1   <= readData1;
         r_rd2   <= readData2;
         r_off   <= offset;
         r_rs    <= rs;
         r_rt    <= rt;
         r_rd    <= rd;
         r_shamt <= shamt;
         r_funct <= funct;
      end
   end

   assign IDEX_valid     = w_valid;
   assign IDEX_readData1 = r_rd1;
   assign IDEX_readData2 = r_rd2;
   assign IDEX_offset    = r_off;
   assign IDEX_rs        = r_rs;
   assign IDEX_rt        = r_rt;
   assign IDEX_rd        = r_rd;
   assign IDEX_shamt     = r_shamt;
   assign IDEX_funct     = r_funct;
   assign IDEX_exctrl    = w_ctrl[EX_LO +: EXCTRL_W];
   assign IDEX_memCtrl   = w_ctrl[MEM_LO +: MEMCTRL_W];
   assign IDEX_wbctrl    = w_ctrl[WB_LO +: WBCTRL_W];
   assign IDEX_Branch    = w_ctrl[0];

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Table-driven bench for idex_pipe_reg plus hand sequences for load-use cases.
// Hazard expectations follow LOAD_USE_DETECT_EN when it is defined for the build.
module tb_idex_pipe_reg;

   typedef struct {
      logic        rst, stall, flush, idv;
      logic [31:0] rd1;
      logic [4:0]  rs, rt, rd;
      logic [3:0]  ex;
      logic [1:0]  mem, wb;
      logic        br;
      logic        e_v;
      logic [31:0] e_rd1;
      logic [4:0]  e_rt, e_rd;
      logic [3:0]  e_ex;
      logic [1:0]  e_mem, e_wb;
      logic        e_br;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, stall, flush, id_valid, Branch_D;
   logic [31:0] readData1, readData2, offset;
   logic [4:0]  rs, rt, rd, shamt;
   logic [5:0]  funct;
   logic [3:0]  exctrl;
   logic [1:0]  memCtrl, wbctrl;

   logic        IDEX_valid, IDEX_Branch, load_use_hazard;
   logic [31:0] IDEX_readData1, IDEX_readData2, IDEX_offset;
   logic [4:0]  IDEX_rs, IDEX_rt, IDEX_rd, IDEX_shamt;
   logic [5:0]  IDEX_funct;
   logic [3:0]  IDEX_exctrl;
   logic [1:0]  IDEX_memCtrl, IDEX_wbctrl;

   int checks = 0;
   int errors = 0;
   int hz_on;
   vec_t tbl[14];

   always #5 clk = ~clk;

   idex_pipe_reg dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .flush           (flush),
      .id_valid        (id_valid),
      .readData1       (readData1),
      .readData2       (readData2),
      .offset          (offset),
      .rs              (rs),
      .rt              (rt),
      .rd              (rd),
      .shamt           (shamt),
      .funct           (funct),
      .exctrl          (exctrl),
      .memCtrl         (memCtrl),
      .wbctrl          (wbctrl),
      .Branch_D        (Branch_D),
      .IDEX_valid      (IDEX_valid),
      .IDEX_readData1  (IDEX_readData1),
      .IDEX_readData2  (IDEX_readData2),
      .IDEX_offset     (IDEX_offset),
      .IDEX_rs         (IDEX_rs),
      .IDEX_rt         (IDEX_rt),
      .IDEX_rd         (IDEX_rd),
      .IDEX_shamt      (IDEX_shamt),
      .IDEX_funct      (IDEX_funct),
      .IDEX_exctrl     (IDEX_exctrl),
      .IDEX_memCtrl    (IDEX_memCtrl),
      .IDEX_wbctrl     (IDEX_wbctrl),
      .IDEX_Branch     (IDEX_Branch),
      .load_use_hazard (load_use_hazard)
   );

   task automatic chk(input string nm, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
      end
   endtask

   // Derived datapath inputs let a single table column cover several fields.
   task automatic drive(input logic r, input logic s, input logic f,
                        input logic v, input logic [31:0] d1,
                        input logic [4:0] a_rs, input logic [4:0] a_rt,
                        input logic [4:0] a_rd, input logic [3:0] ex,
                        input logic [1:0] mem, input logic [1:0] wb,
                        input logic br);
      rst = r; stall = s; flush = f; id_valid = v;
      readData1 = d1; readData2 = ~d1; offset = d1 + 32'd1;
      rs = a_rs; rt = a_rt; rd = a_rd; shamt = a_rd;
      funct = {1'b0, a_rt};
      exctrl = ex; memCtrl = mem; wbctrl = wb; Branch_D = br;
   endtask

   function automatic vec_t mk(
      input logic r, input logic s, input logic f, input logic v,
      input logic [31:0] d1, input logic [4:0] a_rs, input logic [4:0] a_rt,
      input logic [4:0] a_rd, input logic [3:0] ex, input logic [1:0] mem,
      input logic [1:0] wb, input logic br,
      input logic ev, input logic [31:0] ed1, input logic [4:0] ert,
      input logic [4:0] erd, input logic [3:0] eex, input logic [1:0] emem,
      input logic [1:0] ewb, input logic ebr);
      vec_t t;
      t.rst = r; t.stall = s; t.flush = f; t.idv = v; t.rd1 = d1;
      t.rs = a_rs; t.rt = a_rt; t.rd = a_rd; t.ex = ex; t.mem = mem;
      t.wb = wb; t.br = br; t.e_v = ev; t.e_rd1 = ed1; t.e_rt = ert;
      t.e_rd = erd; t.e_ex = eex; t.e_mem = emem; t.e_wb = ewb;
      t.e_br = ebr;
      return t;
   endfunction

   initial begin
`ifdef LOAD_USE_DETECT_EN
      hz_on = 1;
`else
      hz_on = 0;
`endif
      // rst with all-ones inputs
      tbl[0]  = mk(1,0,0,1,32'hFFFF_FFFF,5'h1F,5'h1F,5'h1F,4'hF,2'b11,2'b11,1,
                   0,32'h0,0,0,4'h0,2'b00,2'b00,0);
      tbl[1]  = mk(0,0,0,1,32'h1234_5678,0,0,5,4'h0,2'b00,2'b10,0,
                   1,32'h1234_5678,0,5,4'h0,2'b00,2'b10,0);
      tbl[2]  = mk(0,0,0,1,32'hA,0,7,1,4'h3,2'b01,2'b11,0,
                   1,32'hA,7,1,4'h3,2'b01,2'b11,0);
      // three stalled edges hold rt=7
      tbl[3]  = mk(0,1,0,1,32'hB,0,9,2,4'h1,2'b00,2'b01,0,
                   1,32'hA,7,1,4'h3,2'b01,2'b11,0);
      tbl[4]  = tbl[3];
      tbl[5]  = tbl[3];
      tbl[6]  = mk(0,0,0,1,32'hB,0,9,2,4'h1,2'b00,2'b01,0,
                   1,32'hB,9,2,4'h1,2'b00,2'b01,0);
      tbl[7]  = mk(0,0,1,1,32'hC,0,4,3,4'hF,2'b01,2'b11,1,
                   0,32'hC,4,3,4'h0,2'b00,2'b00,0);
      tbl[8]  = mk(0,0,0,1,32'hD,0,5,4,4'h2,2'b00,2'b10,1,
                   1,32'hD,5,4,4'h2,2'b00,2'b10,1);
      // flush beats stall
      tbl[9]  = mk(0,1,1,1,32'hE,0,6,6,4'hF,2'b01,2'b11,1,
                   0,32'hE,6,6,4'h0,2'b00,2'b00,0);
      // invalid slot carries zero control
      tbl[10] = mk(0,0,0,0,32'h10,0,8,7,4'h5,2'b01,2'b11,1,
                   0,32'h10,8,7,4'h0,2'b00,2'b00,0);
      tbl[11] = mk(0,0,0,1,32'h20,0,2,9,4'h4,2'b10,2'b10,0,
                   1,32'h20,2,9,4'h4,2'b10,2'b10,0);
      // rst beats stall and flush
      tbl[12] = mk(1,1,1,1,32'hFFFF_FFFF,5'h1F,5'h1F,5'h1F,4'hF,2'b11,2'b11,1,
                   0,32'h0,0,0,4'h0,2'b00,2'b00,0);
      tbl[13] = mk(0,0,0,1,32'h30,0,3,10,4'h6,2'b00,2'b10,0,
                   1,32'h30,3,10,4'h6,2'b00,2'b10,0);

      drive(1,0,0,0,0,0,0,0,0,0,0,0);
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].idv,
               tbl[i].rd1, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].ex,
               tbl[i].mem, tbl[i].wb, tbl[i].br);
         @(posedge clk); #1;
         chk("valid", i, 32'(IDEX_valid), 32'(tbl[i].e_v));
         chk("rd1", i, IDEX_readData1, tbl[i].e_rd1);
         chk("rt", i, 32'(IDEX_rt), 32'(tbl[i].e_rt));
         chk("rd", i, 32'(IDEX_rd), 32'(tbl[i].e_rd));
         chk("exctrl", i, 32'(IDEX_exctrl), 32'(tbl[i].e_ex));
         chk("memctrl", i, 32'(IDEX_memCtrl), 32'(tbl[i].e_mem));
         chk("wbctrl", i, 32'(IDEX_wbctrl), 32'(tbl[i].e_wb));
         chk("branch", i, 32'(IDEX_Branch), 32'(tbl[i].e_br));
         if (tbl[i].e_rd1 != 32'h0) begin
            chk("rd2", i, IDEX_readData2, ~tbl[i].e_rd1);
            chk("offset", i, IDEX_offset, tbl[i].e_rd1 + 32'd1);
            chk("shamt", i, 32'(IDEX_shamt), 32'(tbl[i].e_rd));
            chk("funct", i, 32'(IDEX_funct), {27'd0, tbl[i].e_rt});
         end else begin
            chk("rd2_rst", i, IDEX_readData2, 32'h0);
            chk("rs_rst", i, 32'(IDEX_rs), 32'h0);
         end
      end

      // load with rt=3 in EX, dependent instruction in decode
      drive(0,0,0,1,32'h40,0,3,11,4'h0,2'b10,2'b11,0);
      @(posedge clk); #1;
      drive(0,0,0,1,32'h41,3,12,13,4'h1,2'b00,2'b10,0);
      #1;
      chk("hz_dep", 100, 32'(load_use_hazard), 32'(hz_on));
      @(posedge clk); #1;
      chk("hz_bubble_v", 101, 32'(IDEX_valid), 32'(hz_on == 0));
      chk("hz_bubble_wb", 102, 32'(IDEX_wbctrl),
          (hz_on != 0) ? 32'h0 : 32'h2);

      // bubble also outranks stall
      drive(0,0,0,1,32'h42,0,3,11,4'h0,2'b10,2'b11,0);
      @(posedge clk); #1;
      drive(0,1,0,1,32'h43,0,3,14,4'h1,2'b00,2'b10,0);
      #1;
      chk("hz_rt", 103, 32'(load_use_hazard), 32'(hz_on));
      @(posedge clk); #1;
      chk("hz_stall_v", 104, 32'(IDEX_valid), 32'(hz_on == 0));
      chk("hz_stall_rd", 105, 32'(IDEX_rd), (hz_on != 0) ? 32'd14 : 32'd11);

      // load targeting r0 never raises a hazard
      drive(0,0,0,1,32'h50,0,0,11,4'h0,2'b10,2'b11,0);
      @(posedge clk); #1;
      drive(0,0,0,1,32'h51,0,0,12,4'h1,2'b00,2'b10,0);
      #1;
      chk("hz_r0", 106, 32'(load_use_hazard), 32'h0);

      // non-load with matching rt never raises a hazard
      drive(0,0,0,1,32'h60,0,3,11,4'h0,2'b01,2'b00,0);
      @(posedge clk); #1;
      drive(0,0,0,1,32'h61,3,3,12,4'h1,2'b00,2'b10,0);
      #1;
      chk("hz_store", 107, 32'(load_use_hazard), 32'h0);
      @(posedge clk); #1;
      chk("store_next_v", 108, 32'(IDEX_valid), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
